instr_prefetch: RTL and testbench

INSTR_PREFETCH -- requirements
Module: instr_prefetch

---
 rtl/instr_prefetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 48 ++++
 rtl/instr_prefetch.sv | 110 +++++++++++
 tb/tb_instr_prefetch.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_prefetch_pkg.sv
// Shared fetch-side types: FSM encoding, instruction width, reset PC and queue entry layout.
package instr_prefetch_pkg;

  localparam int          ILEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]     pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Shift-style instruction queue: entry 0 is always the head, so head outputs come straight from a register.
module fetch_fifo
  import instr_prefetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int IW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output logic         head_valid,
  output fetch_entry_t head_data
);

  fetch_entry_t  mem [DEPTH];
  logic          do_pop;
  logic          do_push;
  logic [CW-1:0] wr_idx;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  // A same-cycle pop shifts everything down one slot, so the new entry lands one lower.
  assign wr_idx  = count - CW'(do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      if (do_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      end
      if (do_push) mem[wr_idx[IW-1:0]] <= push_data;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_valid = (count != '0);
  assign head_data  = mem[0];

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: one outstanding memory request feeding a DEPTH-entry queue; redirects flush it.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        instr_ready_i
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   pending_pc;
  logic          req_q;
  logic [31:0]   redirect_tgt;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop_eff;
  fetch_entry_t  push_data;
  fetch_entry_t  head;

  assign redirect_tgt = word_align(redirect_pc_i);
  assign push         = (state == ST_WAIT) && imem_rvalid_i && !redirect_i;
  assign pop_eff      = instr_ready_i && (count != '0);
  assign count_next   = count + CW'(push) - CW'(pop_eff);
  assign push_data    = '{pc: fetch_pc, instr: imem_rdata_i};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk_i),
    .rst_n      (rst_i),
    .push       (push),
    .push_data  (push_data),
    .pop        (instr_ready_i),
    .flush      (redirect_i),
    .count      (count),
    .head_valid (instr_valid_o),
    .head_data  (head)
  );

  // fetch_pc only moves on a response or an idle redirect, which keeps the address stable while a request is live.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= ST_IDLE;
      fetch_pc   <= RESET_PC;
      pending_pc <= '0;
      req_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (redirect_i) begin
            fetch_pc <= redirect_tgt;
          end else if (count < CW'(DEPTH)) begin
            state <= ST_WAIT;
            req_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid_i) begin
            if (redirect_i) begin
              fetch_pc <= redirect_tgt;
              state    <= ST_IDLE;
              req_q    <= 1'b0;
            end else begin
              fetch_pc <= fetch_pc + 32'd4;
              if (count_next >= CW'(DEPTH)) begin
                state <= ST_IDLE;
                req_q <= 1'b0;
              end
            end
          end else if (redirect_i) begin
            pending_pc <= redirect_tgt;
            state      <= ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (redirect_i) pending_pc <= redirect_tgt;
          if (imem_rvalid_i) begin
            fetch_pc <= redirect_i ? redirect_tgt : pending_pc;
            state    <= ST_IDLE;
            req_q    <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = fetch_pc;
  assign instr_o     = head.instr;
  assign pc_o        = head.pc;

endmodule

// File: tb/tb_instr_prefetch.sv
// Randomised bench for instr_prefetch: a memory responder plus a queue-level model of the expected instruction stream.
module tb_instr_prefetch;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] KEY    = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_ready;

  instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .instr_valid_o (instr_valid),
    .instr_o       (instr),
    .pc_o          (pc),
    .instr_ready_i (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Model: the queue holds {pc, instr} in fetch order; exp_pc is the next address the prefetcher must ask for.
  logic [63:0] q[$];
  bit          outstanding;
  bit          dropped;
  bit          expect_first_req;
  logic [31:0] out_addr;
  logic [31:0] exp_pc;
  int          lat_cnt;
  int          age;
  int          req_count;
  int          pop_count;

  int lat_min, lat_max, ready_pct, redir_pct;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic knobs(input int lmin, input int lmax, input int rdy, input int rdr);
    lat_min = lmin; lat_max = lmax; ready_pct = rdy; redir_pct = rdr;
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(3, 0))
      0:       t = 32'hFFFF_FFFC | 32'($urandom_range(3, 0));
      1:       t = 32'h0000_0203;
      2:       t = $urandom;
      default: t = $urandom & 32'h0000_0FFF;
    endcase
    return t;
  endfunction

  task automatic step(input bit force_redir, input logic [31:0] force_tgt, input bit force_ready);
    bit          rv, rd, rdy;
    logic [31:0] tgt;
    @(negedge clk);
    check("instr_valid", {31'b0, instr_valid}, {31'b0, q.size() != 0});
    if (q.size() != 0 && instr_valid) begin
      check("pc_o", pc, q[0][63:32]);
      check("instr_o", instr, q[0][31:0]);
    end
    if (expect_first_req) begin
      check("req_after_rst", {31'b0, imem_req}, 32'd1);
      expect_first_req = 0;
    end
    if (outstanding) begin
      check("req_held", {31'b0, imem_req}, 32'd1);
      check("addr_held", imem_addr, out_addr);
      age++;
    end else if (imem_req) begin
      outstanding = 1;
      out_addr    = imem_addr;
      age         = 0;
      req_count++;
      check("req_addr", imem_addr, exp_pc);
      check("room_at_req", {31'b0, q.size() < DEPTH}, 32'd1);
      lat_cnt = int'($urandom_range(lat_max, lat_min));
    end
    rv = outstanding && (lat_cnt == 0);
    if (outstanding && lat_cnt > 0) lat_cnt--;
    rd  = force_redir || (int'($urandom_range(99, 0)) < redir_pct);
    tgt = force_redir ? force_tgt : pick_target();
    rdy = force_ready || (int'($urandom_range(99, 0)) < ready_pct);

    redirect    = rd;
    redirect_pc = rd ? tgt : $urandom;
    imem_rvalid = rv;
    imem_rdata  = rv ? (out_addr ^ KEY) : $urandom;
    instr_ready = rdy;

    if (rd) begin
      q.delete();
      exp_pc = {tgt[31:2], 2'b00};
      if (outstanding && !rv) dropped = 1;
    end else if (rdy && q.size() != 0) begin
      void'(q.pop_front());
      pop_count++;
    end
    if (rv) begin
      if (!rd && !dropped) begin
        q.push_back({out_addr, out_addr ^ KEY});
        exp_pc = out_addr + 32'd4;
      end
      dropped     = 0;
      outstanding = 0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #3;
    rst_n       = 1'b0;
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    instr_ready = 1'b0;
    #1;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_addr", imem_addr, RST_PC);
    repeat (2) @(negedge clk);
    q.delete();
    outstanding      = 0;
    dropped          = 0;
    exp_pc           = RST_PC;
    req_count        = 0;
    pop_count        = 0;
    age              = 0;
    expect_first_req = 1;
    rst_n            = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, n;
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    knobs(0, 0, 100, 0);

    // Zero-latency memory, always-ready consumer: one instruction per cycle once filled.
    apply_reset();
    knobs(0, 0, 100, 0);
    repeat (6) step(0, '0, 0);
    p0 = pop_count;
    repeat (30) step(0, '0, 0);
    check("one_per_cycle", pop_count - p0, 32'd30);

    // Stalled consumer: exactly DEPTH requests, then the request line drops.
    apply_reset();
    knobs(0, 0, 0, 0);
    repeat (20) step(0, '0, 0);
    check("req_count_full", req_count, DEPTH);
    check("req_idle_full", {31'b0, imem_req}, 32'd0);
    check("valid_full", {31'b0, instr_valid}, 32'd1);
    knobs(0, 0, 100, 0);
    repeat (10) step(0, '0, 0);

    // Redirect one cycle into a 3-cycle wait: the in-flight response must be dropped.
    apply_reset();
    knobs(3, 3, 100, 0);
    n = 0;
    do begin step(0, '0, 0); n++; end while (!(outstanding && age == 0) && n < 50);
    check("wait_bound_a", {31'b0, n < 50}, 32'd1);
    step(1, 32'h0000_0100, 0);
    repeat (20) step(0, '0, 0);

    // Queue holds 0,4,8; redirect to an unaligned target with pop and response in the same cycle.
    apply_reset();
    knobs(0, 0, 0, 0);
    n = 0;
    do begin step(0, '0, 0); n++; end while (q.size() != 3 && n < 50);
    check("wait_bound_b", {31'b0, n < 50}, 32'd1);
    step(1, 32'h0000_0203, 1);
    knobs(0, 0, 100, 0);
    repeat (15) step(0, '0, 0);

    // Address wrap from the top of the space.
    apply_reset();
    knobs(0, 0, 100, 0);
    step(1, 32'hFFFF_FFFC, 0);
    repeat (12) step(0, '0, 0);

    // Reset while a request is live and two entries are queued.
    apply_reset();
    knobs(2, 2, 0, 0);
    n = 0;
    do begin step(0, '0, 0); n++; end while (!(q.size() == 2 && outstanding) && n < 100);
    check("wait_bound_c", {31'b0, n < 100}, 32'd1);
    apply_reset();
    knobs(0, 2, 50, 0);
    repeat (20) step(0, '0, 0);

    // Random mix of latency, consumer stalls and redirects.
    apply_reset();
    for (int r = 0; r < 6; r++) begin
      knobs(0, int'($urandom_range(3, 0)), int'($urandom_range(100, 20)), int'($urandom_range(10, 0)));
      repeat (500) step(0, '0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
